// File: rtl/switch_reader.sv
// CPU-readable DIP switch port: synchronizes and debounces 24 switch lines,
// latches per-bit change flags with write-1-to-clear, and raises a level interrupt.
module switch_reader #(
    parameter int DIV     = 20000,
    parameter int SAMPLES = 4
) (
    input  logic        sw_clk,
    input  logic        ledrst,
    input  logic        swread,
    input  logic        swwrite,
    input  logic        swcs,
    input  logic [1:0]  swaddr,
    input  logic [15:0] swwdata,
    input  logic [23:0] sw_in,
    output logic [15:0] swrdata,
    output logic        sw_irq
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;
    logic [23:0]   s1, s2, deb, chg;
    logic [23:0]   hist [SAMPLES-1];
    logic [23:0]   all1, all0, set_mask, clr_mask, chg_next;

    assign tick = (cnt == CW'(DIV - 1));

    // The incoming s2 sample plus the stored SAMPLES-1 samples form the full window.
    always_comb begin
        all1 = s2;
        all0 = ~s2;
        for (int k = 0; k < SAMPLES - 1; k++) begin
            all1 &= hist[k];
            all0 &= ~hist[k];
        end
        set_mask = tick ? ((all1 & ~deb) | (all0 & deb)) : 24'h000000;
        clr_mask = 24'h000000;
        if (swcs && swwrite) begin
            case (swaddr)
                2'b01:   clr_mask[15:0]  = swwdata;
                2'b11:   clr_mask[23:16] = swwdata[7:0];
                default: clr_mask = 24'h000000;
            endcase
        end
        chg_next = (chg & ~clr_mask) | set_mask;
    end

    always_ff @(negedge sw_clk or posedge ledrst) begin
        if (ledrst) begin
            s1     <= '0;
            s2     <= '0;
            cnt    <= '0;
            deb    <= '0;
            chg    <= '0;
            sw_irq <= 1'b0;
            for (int k = 0; k < SAMPLES - 1; k++) begin
                hist[k] <= '0;
            end
        end else begin
            s1  <= sw_in;
            s2  <= s1;
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                hist[0] <= s2;
                for (int k = 1; k < SAMPLES - 1; k++) begin
                    hist[k] <= hist[k-1];
                end
            end
            deb    <= deb ^ set_mask;
            chg    <= chg_next;
            sw_irq <= |chg_next;
        end
    end

    always_comb begin
        swrdata = 16'h0000;
        if (swcs && swread) begin
            case (swaddr)
                2'b00: swrdata = deb[15:0];
                2'b10: swrdata = {8'h00, deb[23:16]};
                2'b01: swrdata = chg[15:0];
                2'b11: swrdata = {8'h00, chg[23:16]};
            endcase
        end
    end

endmodule

// File: tb/tb_switch_reader.sv
// Self-checking bench for switch_reader: directed scenarios plus random traffic,
// checked against a run-length debounce model.
module tb_switch_reader;

    localparam int DIV     = 4;
    localparam int SAMPLES = 3;

    logic        sw_clk;
    logic        ledrst;
    logic        swread;
    logic        swwrite;
    logic        swcs;
    logic [1:0]  swaddr;
    logic [15:0] swwdata;
    logic [23:0] sw_in;
    logic [15:0] swrdata;
    logic        sw_irq;

    switch_reader #(.DIV(DIV), .SAMPLES(SAMPLES)) dut (
        .sw_clk  (sw_clk),
        .ledrst  (ledrst),
        .swread  (swread),
        .swwrite (swwrite),
        .swcs    (swcs),
        .swaddr  (swaddr),
        .swwdata (swwdata),
        .sw_in   (sw_in),
        .swrdata (swrdata),
        .sw_irq  (sw_irq)
    );

    initial begin
        sw_clk = 1'b1;
        forever #5 sw_clk = ~sw_clk;
    end

    int total = 0;
    int bad   = 0;
    logic [15:0] last_rd;

    // Reference: each bit tracks its last sample and how many times in a row it was seen.
    logic [23:0] m_s1, m_s2, m_deb, m_chg, m_last;
    logic        m_irq;
    int          m_run [24];
    int          m_n;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_chg = '0; m_last = '0;
        m_irq = 1'b0; m_n = 0;
        for (int i = 0; i < 24; i++) m_run[i] = SAMPLES - 1;
    endtask

    function automatic logic [15:0] model_read(input logic cs, input logic rd, input logic [1:0] a);
        if (!(cs && rd)) return 16'h0000;
        case (a)
            2'b00:   return m_deb[15:0];
            2'b10:   return {8'h00, m_deb[23:16]};
            2'b01:   return m_chg[15:0];
            default: return {8'h00, m_chg[23:16]};
        endcase
    endfunction

    function automatic logic will_set(input int i);
        return ((m_n % DIV) == DIV - 1) && (m_s2[i] == m_last[i]) &&
               (m_run[i] == SAMPLES - 1) && (m_last[i] != m_deb[i]);
    endfunction

    task automatic model_step(input logic cs, input logic wr, input logic [1:0] a, input logic [15:0] wd);
        logic [23:0] setm, clrm;
        setm = '0;
        clrm = '0;
        if ((m_n % DIV) == DIV - 1) begin
            for (int i = 0; i < 24; i++) begin
                if (m_s2[i] == m_last[i]) begin
                    if (m_run[i] < SAMPLES) m_run[i]++;
                end else begin
                    m_last[i] = m_s2[i];
                    m_run[i]  = 1;
                end
                if (m_run[i] >= SAMPLES && m_last[i] != m_deb[i]) begin
                    m_deb[i] = m_last[i];
                    setm[i]  = 1'b1;
                end
            end
        end
        if (cs && wr) begin
            if (a == 2'b01) clrm[15:0]  = wd;
            if (a == 2'b11) clrm[23:16] = wd[7:0];
        end
        m_chg = (m_chg & ~clrm) | setm;
        m_irq = |m_chg;
        m_s2  = m_s1;
        m_s1  = sw_in;
        m_n++;
    endtask

    // One clock: drive the bus, check the pre-edge read, advance model and DUT, check the interrupt.
    task automatic applyStimulus(input logic cs, input logic rd, input logic wr,
                                 input logic [1:0] a, input logic [15:0] wd);
        swcs = cs; swread = rd; swwrite = wr; swaddr = a; swwdata = wd;
        #1;
        last_rd = swrdata;
        checkOutput("rdata", {16'h0, swrdata}, {16'h0, model_read(cs, rd, a)});
        model_step(cs, wr, a, wd);
        @(negedge sw_clk);
        #1;
        checkOutput("irq", {31'h0, sw_irq}, {31'h0, m_irq});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 16'h0);
    endtask

    task automatic clear_all();
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 16'hFFFF);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b11, 16'h00FF);
    endtask

    initial begin
        int guard;
        ledrst = 1'b0; swread = 1'b0; swwrite = 1'b0; swcs = 1'b0;
        swaddr = 2'b00; swwdata = 16'h0; sw_in = 24'hFFFFFF;
        model_reset();
        #2 ledrst = 1'b1;

        // Reset with all switches on: nothing visible while held.
        swcs = 1'b1; swread = 1'b1;
        for (int a = 0; a < 4; a++) begin
            swaddr = 2'(a);
            @(negedge sw_clk);
            #1;
            checkOutput("rst_rdata", {16'h0, swrdata}, 32'h0);
            checkOutput("rst_irq", {31'h0, sw_irq}, 32'h0);
        end
        ledrst = 1'b0;
        model_reset();
        idle(12);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 16'h0);
        checkOutput("t1_deb_lo", {16'h0, last_rd}, 32'h0000FFFF);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 16'h0);
        checkOutput("t1_deb_hi", {16'h0, last_rd}, 32'h000000FF);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 16'h0);
        checkOutput("t1_chg_lo", {16'h0, last_rd}, 32'h0000FFFF);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 16'h0);
        checkOutput("t1_chg_hi", {16'h0, last_rd}, 32'h000000FF);
        checkOutput("t1_irq", {31'h0, sw_irq}, 32'h1);

        // Drop all switches, then bounce bit 5 with a 6-clock period.
        clear_all();
        sw_in = 24'h000000;
        idle(16);
        clear_all();
        for (int c = 0; c < 40; c++) begin
            sw_in[5] = ((c / 3) % 2) != 0;
            applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 16'h0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 16'h0);
        checkOutput("t2_bounce_deb5", {31'h0, last_rd[5]}, 32'h0);
        sw_in[5] = 1'b1;
        sw_in[0] = 1'b1;
        for (int c = 0; c < 16; c++) applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 16'h0);
        checkOutput("t2_deb5", {31'h0, last_rd[5]}, 32'h1);

        // Write-1-to-clear on the low change register.
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 16'h0);
        checkOutput("t3_chg", {16'h0, last_rd}, 32'h00000021);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 16'h0001);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 16'h0);
        checkOutput("t3_chg_after1", {16'h0, last_rd}, 32'h00000020);
        checkOutput("t3_irq1", {31'h0, sw_irq}, 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 16'h0020);
        checkOutput("t3_rdwr_pre", {16'h0, last_rd}, 32'h00000020);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 16'h0);
        checkOutput("t3_chg_after2", {16'h0, last_rd}, 32'h0);
        checkOutput("t3_irq0", {31'h0, sw_irq}, 32'h0);

        // Set and clear of chg[20] on the same edge: set wins.
        sw_in[20] = 1'b1;
        guard = 0;
        while (!will_set(20) && guard < 40) begin
            idle(1);
            guard++;
        end
        if (guard >= 40) checkOutput("t4_timeout", 32'h1, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b11, 16'h0010);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 16'h0);
        checkOutput("t4_setwins", {16'h0, last_rd}, 32'h00000010);
        clear_all();

        // Gated reads and ignored writes to the level registers.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 16'h0);
        checkOutput("t5_nocs", {16'h0, last_rd}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
        checkOutput("t5_nord", {16'h0, last_rd}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 16'hFFFF);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 16'hFFFF);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 16'h0);
        checkOutput("t5_deb_kept", {16'h0, last_rd}, 32'h00000021);

        // Pulse reset while bit 1 has two of three samples toward 1.
        sw_in[1] = 1'b1;
        guard = 0;
        while (!(m_last[1] == 1'b1 && m_run[1] == SAMPLES - 1) && guard < 40) begin
            idle(1);
            guard++;
        end
        if (guard >= 40) checkOutput("t6_timeout", 32'h1, 32'h0);
        ledrst = 1'b1;
        model_reset();
        @(negedge sw_clk);
        #1;
        ledrst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 16'h0);
            if (c == 11) checkOutput("t6_deb_hold", {16'h0, last_rd}, 32'h0);
        end
        checkOutput("t6_deb_acq", {16'h0, last_rd}, 32'h00000023);

        // Random bus traffic and occasional switch flips.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) == 0) sw_in[$urandom_range(0, 23)] ^= 1'b1;
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                          2'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
